// File: rtl/async_fifo_wptr_full.sv
// Write-side pointer and status stage of the async FIFO.
// Produces the Gray pointer that crosses domains, plus full/level/overflow.
module async_fifo_bin2gray #(
  parameter int SIGNAL_WIDTH = 5
) (
  input  logic [SIGNAL_WIDTH-1:0] bin,
  output logic [SIGNAL_WIDTH-1:0] gray
);
  assign gray = bin ^ (bin >> 1);
endmodule

module async_fifo_wptr_full #(
  parameter int ADDR_WIDTH   = 4,
  parameter int AFULL_THRESH = 12
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  wr_en,
  input  logic [ADDR_WIDTH:0]   rptr_gray_sync,
  output logic                  wr_accept,
  output logic [ADDR_WIDTH-1:0] waddr,
  output logic [ADDR_WIDTH:0]   wptr_bin,
  output logic [ADDR_WIDTH:0]   wptr_gray,
  output logic                  full,
  output logic                  almost_full,
  output logic [ADDR_WIDTH:0]   wr_level,
  output logic                  overflow
);
  localparam int PW = ADDR_WIDTH + 1;
  localparam logic [PW:0] AF_T = (PW+1)'(AFULL_THRESH);

  logic [PW-1:0] bin_next;
  logic [PW-1:0] gray_next;
  logic [PW-1:0] rbin_sync;
  logic [PW-1:0] level_next;
  logic [PW-1:0] full_cmp;

  assign wr_accept = wr_en & ~full;
  assign waddr     = wptr_bin[ADDR_WIDTH-1:0];
  assign bin_next  = wptr_bin + {{ADDR_WIDTH{1'b0}}, wr_accept};

  async_fifo_bin2gray #(
    .SIGNAL_WIDTH(PW)
  ) u_b2g (
    .bin  (bin_next),
    .gray (gray_next)
  );

  // Full when write pointer is one lap ahead: top two Gray bits inverted.
  generate
    if (ADDR_WIDTH == 1) begin : g_cmp1
      assign full_cmp = ~rptr_gray_sync;
    end else begin : g_cmpn
      assign full_cmp = {~rptr_gray_sync[PW-1:PW-2],
                         rptr_gray_sync[PW-3:0]};
    end
  endgenerate

  always_comb begin
    rbin_sync = '0;
    rbin_sync[PW-1] = rptr_gray_sync[PW-1];
    for (int i = PW - 2; i >= 0; i--) begin
      rbin_sync[i] = rbin_sync[i+1] ^ rptr_gray_sync[i];
    end
  end

  assign level_next = bin_next - rbin_sync;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wptr_bin    <= '0;
      wptr_gray   <= '0;
      full        <= 1'b0;
      almost_full <= 1'b0;
      wr_level    <= '0;
      overflow    <= 1'b0;
    end else begin
      wptr_bin    <= bin_next;
      wptr_gray   <= gray_next;
      full        <= (gray_next == full_cmp);
      almost_full <= ({1'b0, level_next} >= AF_T);
      wr_level    <= level_next;
      overflow    <= overflow | (wr_en & full);
    end
  end
endmodule
